barrel_shifter_pipe: RTL
========================

Name: barrel_shifter_pipe

Overview:
Parametrised, pipelined, multi-mode barrel shifter for the AWGN datapath. It is the successor to the fixed 48-bit combinational right shifter.
- Generalised data width.
- Logical right, arithmetic right, logical left and rotate-right modes.
- One register per shift level, with valid/ready handshake and backpressure.
- Used by normalisation and scaling stages that need a high clock rate.

Parameters:
DATA_W, 48, data width in bits (>=2)
SHIFT_W, 6, shift-amount width; number of shift levels and pipeline stages (2^(SHIFT_W-1) < 2*DATA_W required)

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept input this cycle
in_data  input  DATA_W  operand
in_shift  input  SHIFT_W  shift amount, unsigned
in_mode  input  2  00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  DATA_W  shifted result

Behaviour:
- Reset:
  - All stage valid flags, data, shift and mode registers clear asynchronously.
  - out_valid=0, out_data=0.
  - in_ready=1 once reset_n is high.
- Structure: SHIFT_W stages. Stage k (k = SHIFT_W-1 down to 0, MSB level first) conditionally shifts by 2^k when the captured shift bit k = 1.
  - Each stage registers: data, remaining shift bits, mode, valid.
- Latency: exactly SHIFT_W cycles from the in_valid&&in_ready edge to out_valid, when there is no stall. Throughput is 1 word/cycle.
- Stall rule:
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stall, every stage register holds; no bubble collapsing.
  - Transfers happen only when valid&&ready on each side.
  - out_data is stable while out_valid && !out_ready.
- Mode fill rules per level shift of s = 2^k:
  - 00: zeros enter at the MSB.
  - 01: copies of the current MSB (bit DATA_W-1) enter at the MSB.
  - 10: zeros enter at the LSB.
  - 11: bits leaving the LSB re-enter at the MSB.
- Levels with 2^k >= DATA_W:
  - Logical modes: result 0.
  - Arithmetic: all sign bits.
  - Rotate: rotate by 2^k mod DATA_W.
- Overall result is therefore:
  - shift >= DATA_W: 0 for logical modes, sign fill for arithmetic.
  - Rotate: rotation by in_shift mod DATA_W.
- Shift amount 0: data passes unchanged, still with SHIFT_W latency.
- Reset mid-operation: all in-flight words are discarded. No out_valid pulse after reset release until new input has propagated.
- Simultaneous accept and output on the same cycle is allowed at full rate.

Optional Feature:
Macro BARREL_SHIFTER_PIPE_STICKY_EN.
- When defined:
  - Adds output port out_sticky (1 bit), pipelined alongside the data.
  - Value is the OR of every bit shifted out past the LSB in modes 00 and 01.
  - Forced to 0 in modes 10 and 11.
  - Reset value 0; held during stall.
  - Used for rounding in downstream normalisation.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
All scenarios use DATA_W=48, SHIFT_W=6.
- Logical right: in_data=0xFFFF00001234, shift=4, mode=00 -> out_data=0x0FFFF0000123 with out_valid exactly 6 cycles after accept; shift=48 -> 0x000000000000.
- Arithmetic right: in_data=0x800000000000, mode=01, shift=47 -> 0xFFFFFFFFFFFF; shift=63 -> 0xFFFFFFFFFFFF; in_data=0x400000000000, shift=2 -> 0x100000000000.
- Left and rotate:
  - mode=10, in_data=0x000000000001, shift=47 -> 0x800000000000; shift=48 -> 0.
  - mode=11, in_data=0x000000000001, shift=1 -> 0x800000000000; shift=49 -> 0x800000000000.
- Backpressure: 10 back-to-back words (in_data=i, shift=0, mode=00), out_ready low for 4 cycles once out_valid first rises -> in_ready low during stall, outputs 0..9 in order, none lost or duplicated, out_data stable while stalled.
- Reset mid-flight: 3 words accepted, reset_n pulsed low 1 cycle before the first output -> out_valid=0 immediately and stays 0 until a new word has completed its 6-cycle latency.
- Sticky (with BARREL_SHIFTER_PIPE_STICKY_EN):
  - mode=00, in_data=0x000000000003, shift=1 -> out_data=0x000000000001, out_sticky=1.
  - in_data=0x000000000004, shift=2 -> out_sticky=0.
  - mode=10, any data -> out_sticky=0.

Source files
------------

// File: rtl/barrel_shifter_pipe_if.sv
// Stream interface for barrel_shifter_pipe: operand side (in_*) and result side (out_*).
// The slave modport is the shifter's view; the master modport is the view of whoever drives
// operands and consumes results.
// out_sticky is present only when BARREL_SHIFTER_PIPE_STICKY_EN is defined.
//
// Handshake: a word moves on a rising clk edge only when valid && ready are both high on
// that side. A producer holds valid and its payload steady until the word is taken.
interface barrel_shifter_pipe_if #(
  parameter int DATA_W  = 48,
  parameter int SHIFT_W = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [SHIFT_W-1:0] in_shift;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
  logic               out_sticky;
`endif

  modport slave (
    input  in_valid, in_data, in_shift, in_mode, out_ready,
    output in_ready, out_valid, out_data
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
    , output out_sticky
`endif
  );

  modport master (
    output in_valid, in_data, in_shift, in_mode, out_ready,
    input  in_ready, out_valid, out_data
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
    , input out_sticky
`endif
  );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined multi-mode barrel shifter with one register stage per shift level.
//
// Shift levels are applied MSB first: pipeline stage j applies the shift by
// 2^(SHIFT_W-1-j).
// Modes: 00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
// Optional macro BARREL_SHIFTER_PIPE_STICKY_EN adds out_sticky. out_sticky is the OR of all
// bits lost past the LSB in the right-shift modes.
//
// Backpressure: while the output holds a word that is not taken, the whole pipe freezes and
// in_ready drops. Bubbles inside the pipe are not collapsed.
module barrel_shifter_pipe #(
  parameter int DATA_W  = 48,
  parameter int SHIFT_W = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  barrel_shifter_pipe_if.slave   bus
);

  // Stage registers; index j is the pipeline stage, with j = 0 nearest the input.
  logic [DATA_W-1:0]  r_data  [SHIFT_W];
  logic [SHIFT_W-1:0] r_shift [SHIFT_W];
  logic [1:0]         r_mode  [SHIFT_W];
  logic [SHIFT_W-1:0] r_valid;
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
  logic [SHIFT_W-1:0] r_sticky;
`endif

  // Inputs seen by each stage, and the values each stage will register.
  logic [DATA_W-1:0]  w_src_data  [SHIFT_W];
  logic [SHIFT_W-1:0] w_src_shift [SHIFT_W];
  logic [1:0]         w_src_mode  [SHIFT_W];
  logic [SHIFT_W-1:0] w_src_valid;
  logic [DATA_W-1:0]  w_nxt_data  [SHIFT_W];
  logic [SHIFT_W-1:0] w_nxt_shift [SHIFT_W];
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
  logic [SHIFT_W-1:0] w_src_sticky;
  logic [SHIFT_W-1:0] w_nxt_sticky;
`endif
  logic               w_stall;

  // Applies one level's shift of s bit positions.
  // SV shifts by s >= DATA_W already give 0 for the logical modes and all sign bits for
  // the arithmetic mode. Rotation by 0 works because d << DATA_W is 0.
  function automatic logic [DATA_W-1:0] f_level(input logic [DATA_W-1:0] d,
                                                input logic [1:0] m, input int s);
    int r;
    r = s % DATA_W;
    case (m)
      2'b00:   f_level = d >> s;
      2'b01:   f_level = $unsigned($signed(d) >>> s);
      2'b10:   f_level = d << s;
      default: f_level = (d >> r) | (d << (DATA_W - r));
    endcase
  endfunction

`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
  // Returns the OR of the bits that a right shift by s pushes out past the LSB.
  function automatic logic f_lost(input logic [DATA_W-1:0] d, input int s);
    f_lost = |(d & ~({DATA_W{1'b1}} << s));
  endfunction
`endif

  assign w_stall       = r_valid[SHIFT_W-1] && !bus.out_ready;
  assign bus.in_ready  = !w_stall;
  assign bus.out_valid = r_valid[SHIFT_W-1];
  assign bus.out_data  = r_data[SHIFT_W-1];
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
  assign bus.out_sticky = r_sticky[SHIFT_W-1];
`endif

  // Computes each stage's next value.
  // The shift field moves left one bit per stage, so every stage tests the field's MSB.
  always_comb begin
    w_src_data[0]  = bus.in_data;
    w_src_shift[0] = bus.in_shift;
    w_src_mode[0]  = bus.in_mode;
    w_src_valid[0] = bus.in_valid;
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
    w_src_sticky[0] = 1'b0;
`endif
    for (int j = 1; j < SHIFT_W; j++) begin
      w_src_data[j]  = r_data[j-1];
      w_src_shift[j] = r_shift[j-1];
      w_src_mode[j]  = r_mode[j-1];
      w_src_valid[j] = r_valid[j-1];
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
      w_src_sticky[j] = r_sticky[j-1];
`endif
    end
    for (int j = 0; j < SHIFT_W; j++) begin
      w_nxt_shift[j] = w_src_shift[j] << 1;
      if (w_src_shift[j][SHIFT_W-1])
        w_nxt_data[j] = f_level(w_src_data[j], w_src_mode[j], 1 << (SHIFT_W - 1 - j));
      else
        w_nxt_data[j] = w_src_data[j];
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
      w_nxt_sticky[j] = w_src_sticky[j] ||
                        (w_src_shift[j][SHIFT_W-1] && !w_src_mode[j][1] &&
                         f_lost(w_src_data[j], 1 << (SHIFT_W - 1 - j)));
`endif
    end
  end

  // Advances every stage together unless the output is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
      r_sticky <= '0;
`endif
      for (int j = 0; j < SHIFT_W; j++) begin
        r_data[j]  <= '0;
        r_shift[j] <= '0;
        r_mode[j]  <= '0;
      end
    end else if (!w_stall) begin
      r_valid <= w_src_valid;
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
      r_sticky <= w_nxt_sticky;
`endif
      for (int j = 0; j < SHIFT_W; j++) begin
        r_data[j]  <= w_nxt_data[j];
        r_shift[j] <= w_nxt_shift[j];
        r_mode[j]  <= w_src_mode[j];
      end
    end
  end

endmodule
